layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: launches neurons, streams inputs, waits, collects, argmax.
// Optional ReLU on collected values: define LAYER_SEQ_RELU_EN.
module layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_NEU   = 10,
  parameter int TIMEOUT = 2047
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [9:0]              in_addr,
  output logic                    in_rd_en,
  output logic                    neu_start,
  input  logic [N_NEU-1:0]        neu_done,
  output logic [3:0]              neu_sel,
  input  logic signed [39:0]      neu_dout,
  output logic                    res_we,
  output logic [3:0]              res_addr,
  output logic signed [39:0]      res_data,
  output logic [3:0]              class_idx,
  output logic                    class_valid,
  output logic                    busy,
  output logic                    error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_STREAM, S_WAIT, S_COLLECT, S_FINISH
  } state_t;

  localparam logic [15:0] IN_LAST  = 16'(N_IN - 1);
  localparam logic [15:0] NEU_LAST = 16'(N_NEU - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [N_NEU-1:0]   done_q;
  logic [N_NEU-1:0]   done_now;
  logic               done_full;
  logic signed [39:0] best_val_q;
  logic [3:0]         best_idx_q;
  logic [3:0]         class_q;
  logic               err_q;
  logic signed [39:0] proc;
  logic               take;
  logic [3:0]         win_idx;
  logic               accept;
  logic               timeout;

`ifdef LAYER_SEQ_RELU_EN
  assign proc = neu_dout[39] ? '0 : neu_dout;
`else
  assign proc = neu_dout;
`endif

  assign done_now  = done_q | neu_done;
  assign done_full = &done_now;
  assign take      = (cnt_q == '0) || (proc > best_val_q);
  assign win_idx   = take ? cnt_q[3:0] : best_idx_q;
  assign accept    = (state_q == S_IDLE) && start;
  assign timeout   = (state_q == S_WAIT) && !done_full &&
                     (cnt_q == TO_LAST);

  assign class_idx = class_q;
  assign error     = err_q;

  // state and shared step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // sticky done capture, cleared as LAUNCH is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else if (accept) begin
      done_q <= '0;
    end else if (state_q != S_IDLE) begin
      done_q <= done_now;
    end
  end

  // running argmax over the collected values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else if (state_q == S_COLLECT && take) begin
      best_val_q <= proc;
      best_idx_q <= cnt_q[3:0];
    end
  end

  // winner latch and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
      if (timeout)
        class_q <= '0;
      else if (state_q == S_COLLECT && cnt_q == NEU_LAST)
        class_q <= win_idx;
    end
  end

  // next state and per-state outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_addr     = '0;
    in_rd_en    = 1'b0;
    neu_start   = 1'b0;
    neu_sel     = '0;
    res_we      = 1'b0;
    res_addr    = '0;
    res_data    = '0;
    class_valid = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
          cnt_d   = '0;
        end
      end
      S_LAUNCH: begin
        neu_start = 1'b1;
        state_d   = S_STREAM;
        cnt_d     = '0;
      end
      S_STREAM: begin
        in_rd_en = 1'b1;
        in_addr  = cnt_q[9:0];
        if (cnt_q == IN_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (done_full) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COLLECT: begin
        neu_sel  = cnt_q[3:0];
        res_we   = 1'b1;
        res_addr = cnt_q[3:0];
        res_data = proc;
        if (cnt_q == NEU_LAST) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FINISH: begin
        class_valid = 1'b1;
        state_d     = S_IDLE;
        cnt_d       = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed vectors for layer_sequencer
// with N_IN=4, N_NEU=3, TIMEOUT=16.
module tb_layer_sequencer;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [9:0]         in_addr;
  logic               in_rd_en;
  logic               neu_start;
  logic [2:0]         neu_done;
  logic [3:0]         neu_sel;
  logic signed [39:0] neu_dout;
  logic               res_we;
  logic [3:0]         res_addr;
  logic signed [39:0] res_data;
  logic [3:0]         class_idx;
  logic               class_valid;
  logic               busy;
  logic               error;

  logic signed [39:0] vals [3];

  int total = 0;
  int bad   = 0;

  int obs_lat, obs_nres, obs_valid, obs_idx, obs_busy;
  int obs_nst, obs_nrd, obs_err, obs_addr_ok;
  logic signed [39:0] obs_res [3];

  typedef struct {
    logic signed [39:0] d0, d1, d2;
    logic signed [39:0] r0, r1, r2;
    int idx;
  } vec_t;

  vec_t tbl [4];

  layer_sequencer #(
    .N_IN(4), .N_NEU(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_addr(in_addr), .in_rd_en(in_rd_en),
    .neu_start(neu_start), .neu_done(neu_done),
    .neu_sel(neu_sel), .neu_dout(neu_dout),
    .res_we(res_we), .res_addr(res_addr),
    .res_data(res_data), .class_idx(class_idx),
    .class_valid(class_valid), .busy(busy),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external neuron mux model
  always_comb begin
    neu_dout = '0;
    if (neu_sel < 4'd3)
      neu_dout = vals[neu_sel[1:0]];
  end

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // one inference; t=0 is the start cycle
  task automatic run(input bit hang, input bit poke);
    int last;
    int post;
    bit seen;
    last = -100;
    post = 0;
    seen = 0;
    obs_lat = -1;
    obs_nres = 0;
    obs_valid = 0;
    obs_idx = -1;
    obs_busy = 0;
    obs_nst = 0;
    obs_nrd = 0;
    obs_err = -1;
    obs_addr_ok = 1;
    for (int i = 0; i < 3; i++) obs_res[i] = 'x;
    for (int t = 0; t < 80 && post < 3; t++) begin
      @(negedge clk);
      start = (t == 0) || (poke && t == 6);
      neu_done = (t == last + 2) ?
                 (hang ? 3'b011 : 3'b111) : 3'b000;
      #1;
      if (busy) obs_busy++;
      if (neu_start) obs_nst++;
      if (in_rd_en) begin
        if (in_addr != 10'(obs_nrd)) obs_addr_ok = 0;
        if (in_addr == 10'd3) last = t;
        obs_nrd++;
      end
      if (res_we) begin
        if (obs_nres < 3) begin
          obs_res[obs_nres] = res_data;
          if (res_addr != 4'(obs_nres)) obs_addr_ok = 0;
        end
        obs_nres++;
      end
      if (class_valid) begin
        obs_valid++;
        obs_idx = int'(class_idx);
        obs_err = int'(error);
        if (!seen) obs_lat = t;
        seen = 1;
      end
      if (seen) post++;
    end
    start = 1'b0;
    neu_done = '0;
  endtask

  task automatic check_run(input vec_t v, input bit hang);
    int lat;
    lat = hang ? 22 : 11;
    chk("addr_seq", obs_addr_ok, 1);
    chk("rd_count", obs_nrd, 4);
    chk("latency", obs_lat, lat);
    chk("valid_count", obs_valid, 1);
    chk("busy_cycles", obs_busy, lat);
    chk("neu_start_count", obs_nst, 1);
    chk("class_idx", obs_idx, hang ? 0 : v.idx);
    chk("error_at_finish", obs_err, hang ? 1 : 0);
    chk("res_count", obs_nres, hang ? 0 : 3);
    if (!hang) begin
      chk("res_data0", obs_res[0], v.r0);
      chk("res_data1", obs_res[1], v.r1);
      chk("res_data2", obs_res[2], v.r2);
    end
  endtask

  task automatic load(input vec_t v);
    vals[0] = v.d0;
    vals[1] = v.d1;
    vals[2] = v.d2;
  endtask

  initial begin
    bit found;
`ifdef LAYER_SEQ_RELU_EN
    tbl[0] = '{40'sd5, 40'sd9, -40'sd3, 40'sd5, 40'sd9, 40'sd0, 1};
    tbl[1] = '{40'sd7, 40'sd7, 40'sd2, 40'sd7, 40'sd7, 40'sd2, 0};
    tbl[2] = '{-40'sd8, -40'sd2, -40'sd5, 40'sd0, 40'sd0, 40'sd0, 0};
    tbl[3] = '{40'sd0, -40'sd1, 40'sd3, 40'sd0, 40'sd0, 40'sd3, 2};
`else
    tbl[0] = '{40'sd5, 40'sd9, -40'sd3, 40'sd5, 40'sd9, -40'sd3, 1};
    tbl[1] = '{40'sd7, 40'sd7, 40'sd2, 40'sd7, 40'sd7, 40'sd2, 0};
    tbl[2] = '{-40'sd8, -40'sd2, -40'sd5, -40'sd8, -40'sd2, -40'sd5, 1};
    tbl[3] = '{40'sd0, -40'sd1, 40'sd3, 40'sd0, -40'sd1, 40'sd3, 2};
`endif
    rst_n = 1'b0;
    start = 1'b0;
    neu_done = '0;
    for (int i = 0; i < 3; i++) vals[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_in_rd_en", in_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      load(tbl[k]);
      run(1'b0, 1'b0);
      check_run(tbl[k], 1'b0);
    end

    // neuron 2 never finishes: timeout path
    run(1'b1, 1'b0);
    check_run(tbl[3], 1'b1);
    #1;
    chk("error_sticky_idle", error, 1);

    // next start clears error; start during WAIT ignored
    load(tbl[0]);
    run(1'b0, 1'b1);
    check_run(tbl[0], 1'b0);

    // reset in the middle of streaming
    load(tbl[1]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (in_rd_en && in_addr == 10'd2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_addr2", found, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_rd_en", in_rd_en, 0);
    chk("mid_rst_in_addr", in_addr, 0);
    chk("mid_rst_class_idx", class_idx, 0);
    chk("mid_rst_class_valid", class_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 1'b0);
    check_run(tbl[1], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
